// File: rtl/load_choose.sv
// RV64 load-result formatter: extracts the b/h/w/d field from memory read data,
// sign- or zero-extends it for write-back, and keeps a registered copy with load/illegal flags.
module load_choose #(
  parameter int         XLEN        = 64,
  parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] dataReadFromMemory,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] writeDataReg,
  output logic [XLEN-1:0] writeDataReg_q,
  output logic            load_valid_q,
  output logic            load_illegal_q
);

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_ILL = 3'b111
  } funct3_e;

  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic            is_load;
  logic [XLEN-1:0] load_fmt;
  logic [XLEN-1:0] writeDataReg_d;
  logic            load_valid_d;
  logic            load_illegal_d;

  assign is_load = (opcode == LOAD_OPCODE);

  // Unknown funct3 falls into default, so the selected value is never a held register.
  always_comb begin
    load_fmt = '0;
    case (funct3)
      F3_LB:   load_fmt = sext8(dataReadFromMemory[7:0]);
      F3_LH:   load_fmt = sext16(dataReadFromMemory[15:0]);
      F3_LW:   load_fmt = sext32(dataReadFromMemory[31:0]);
      F3_LD:   load_fmt = dataReadFromMemory;
      F3_LBU:  load_fmt = {{(XLEN-8){1'b0}}, dataReadFromMemory[7:0]};
      F3_LHU:  load_fmt = {{(XLEN-16){1'b0}}, dataReadFromMemory[15:0]};
      F3_LWU:  load_fmt = {{(XLEN-32){1'b0}}, dataReadFromMemory[31:0]};
      default: load_fmt = '0;
    endcase
  end

  assign writeDataReg   = is_load ? load_fmt : dataReadFromMemory;
  assign writeDataReg_d = writeDataReg;
  assign load_valid_d   = is_load;
  assign load_illegal_d = is_load && (funct3 == F3_ILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeDataReg_q <= '0;
      load_valid_q   <= 1'b0;
      load_illegal_q <= 1'b0;
    end else begin
      writeDataReg_q <= writeDataReg_d;
      load_valid_q   <= load_valid_d;
      load_illegal_q <= load_illegal_d;
    end
  end

endmodule

// File: tb/tb_load_choose.sv
// Directed bench for load_choose: expected values are queued when stimulus is
// driven and popped when the corresponding combinational or registered output is sampled.
module tb_load_choose;

  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] R_OP  = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic [63:0] dataReadFromMemory;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] writeDataReg;
  logic [63:0] writeDataReg_q;
  logic        load_valid_q;
  logic        load_illegal_q;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  load_choose dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dataReadFromMemory(dataReadFromMemory),
    .opcode            (opcode),
    .funct3            (funct3),
    .writeDataReg      (writeDataReg),
    .writeDataReg_q    (writeDataReg_q),
    .load_valid_q      (load_valid_q),
    .load_illegal_q    (load_illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive one vector after a falling edge, check the combinational result,
  // then check the registered copy and flags one rising edge later.
  task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [63:0] d, input logic [63:0] exp_w,
                     input logic exp_v, input logic exp_i);
    @(negedge clk);
    opcode = op;
    funct3 = f3;
    dataReadFromMemory = d;
    push({tag, "_comb"}, exp_w);
    push({tag, "_q"}, exp_w);
    push({tag, "_valid_q"}, {63'b0, exp_v});
    push({tag, "_illegal_q"}, {63'b0, exp_i});
    #1 check(writeDataReg);
    @(posedge clk);
    #1;
    check(writeDataReg_q);
    check({63'b0, load_valid_q});
    check({63'b0, load_illegal_q});
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = LD_OP;
    funct3 = 3'b000;
    dataReadFromMemory = 64'h0000_0000_0000_00FE;

    #2;
    push("rst_q", 64'h0);
    push("rst_valid_q", 64'h0);
    push("rst_illegal_q", 64'h0);
    push("rst_comb_unaffected", 64'hFFFF_FFFF_FFFF_FFFE);
    check(writeDataReg_q);
    check({63'b0, load_valid_q});
    check({63'b0, load_illegal_q});
    check(writeDataReg);

    @(negedge clk);
    rst_n = 1'b1;

    vec("lb_pos",     LD_OP, 3'b000, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0002, 1'b1, 1'b0);
    vec("lb_neg",     LD_OP, 3'b000, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    vec("lb_upper",   LD_OP, 3'b000, 64'h0000_0000_0000_00FE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    vec("lh_pos",     LD_OP, 3'b001, 64'h0000_0000_0000_0004, 64'h0000_0000_0000_0004, 1'b1, 1'b0);
    vec("lh_neg",     LD_OP, 3'b001, 64'h0000_0000_0000_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
    vec("lw_pos",     LD_OP, 3'b010, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0008, 1'b1, 1'b0);
    vec("lw_neg",     LD_OP, 3'b010, 64'h0000_0000_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0);
    vec("lbu",        LD_OP, 3'b100, 64'hFFFF_FFFF_FFFF_FF90, 64'h0000_0000_0000_0090, 1'b1, 1'b0);
    vec("lhu",        LD_OP, 3'b101, 64'hFFFF_FFFF_FFFF_8020, 64'h0000_0000_0000_8020, 1'b1, 1'b0);
    vec("lwu",        LD_OP, 3'b110, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 1'b1, 1'b0);
    vec("ld",         LD_OP, 3'b011, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b1, 1'b0);
    vec("lh_upper",   LD_OP, 3'b001, 64'h1234_5678_9ABC_7FFF, 64'h0000_0000_0000_7FFF, 1'b1, 1'b0);
    vec("illegal",    LD_OP, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b1);
    vec("nonload",    R_OP,  3'b000, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234, 1'b0, 1'b0);
    vec("nonload_f3", R_OP,  3'b111, 64'h0000_0000_0000_00FE, 64'h0000_0000_0000_00FE, 1'b0, 1'b0);
    vec("reg_lb",     LD_OP, 3'b000, 64'h0000_0000_0000_00FE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

    // Mid-cycle input change: registered outputs hold, combinational output follows.
    @(negedge clk);
    opcode = R_OP;
    funct3 = 3'b111;
    dataReadFromMemory = 64'h0000_0000_0000_5555;
    push("hold_comb", 64'h0000_0000_0000_5555);
    push("hold_q", 64'hFFFF_FFFF_FFFF_FFFE);
    push("hold_valid_q", 64'h1);
    #1;
    check(writeDataReg);
    check(writeDataReg_q);
    check({63'b0, load_valid_q});
    push("hold_next_q", 64'h0000_0000_0000_5555);
    push("hold_next_valid_q", 64'h0);
    @(posedge clk);
    #1;
    check(writeDataReg_q);
    check({63'b0, load_valid_q});

    // Set up nonzero registered state including the illegal flag, then reset between edges.
    vec("pre_rst", LD_OP, 3'b111, 64'h0000_0000_0000_0001, 64'h0, 1'b1, 1'b1);
    vec("pre_rst2", LD_OP, 3'b011, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0);
    @(negedge clk);
    funct3 = 3'b111;
    #1 rst_n = 1'b0;
    #1;
    push("arst_q", 64'h0);
    push("arst_valid_q", 64'h0);
    push("arst_illegal_q", 64'h0);
    check(writeDataReg_q);
    check({63'b0, load_valid_q});
    check({63'b0, load_illegal_q});
    dataReadFromMemory = 64'h0000_0000_0000_0080;
    funct3 = 3'b000;
    push("arst_comb_tracks", 64'hFFFF_FFFF_FFFF_FF80);
    #1 check(writeDataReg);
    @(posedge clk);
    #1;
    push("arst_edge_q", 64'h0);
    push("arst_edge_valid_q", 64'h0);
    check(writeDataReg_q);
    check({63'b0, load_valid_q});
    @(negedge clk);
    rst_n = 1'b1;
    push("release_q", 64'hFFFF_FFFF_FFFF_FF80);
    push("release_valid_q", 64'h1);
    @(posedge clk);
    #1;
    check(writeDataReg_q);
    check({63'b0, load_valid_q});

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
